// File: rtl/mask_mod.sv
// M-ary ASK modulator: one-symbol buffer, phase/sample sequencer and a three-stage
// sine LUT * gain pipeline producing one signed carrier sample per clk while running.
module mask_mod #(
  parameter int DW          = 12,
  parameter int SYM_BITS    = 2,
  parameter int LUT_DEPTH   = 25,
  parameter int CYC_PER_SYM = 1,
  parameter int GF          = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 sym_valid,
  input  logic [SYM_BITS-1:0]  sym_data,
  output logic                 sym_ready,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 sym_start,
  output logic                 underrun,
  output logic                 busy
);

  localparam int L   = 2 ** SYM_BITS;
  localparam int SPS = LUT_DEPTH * CYC_PER_SYM;
  localparam int PW  = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int CW  = $clog2(SPS);
  localparam int GW  = GF + 1;
  localparam int PRW = DW + GF + 2;
  localparam logic [PW-1:0] LAST_PHASE = PW'(LUT_DEPTH - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(SPS - 1);

  // round((2**(DW-1)-1)*sin(2*pi*n/LUT_DEPTH)) via a Q28 Taylor series, folded to [0, pi]
  function automatic logic [DW-1:0] sine_entry(input int n);
    longint pi_q, x, x2, term, sum, amp, mag;
    int     m;
    logic   neg;
    pi_q = 64'sd843314857;
    neg  = (2 * n > LUT_DEPTH);
    m    = neg ? LUT_DEPTH - n : n;
    x    = (2 * pi_q * m) / LUT_DEPTH;
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -((term * x2) >>> 28) / ((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (DW - 1)) - 1;
    mag = (amp * sum + (longint'(1) <<< 27)) >>> 28;
    return DW'(neg ? -mag : mag);
  endfunction

  function automatic logic [LUT_DEPTH*DW-1:0] build_sine_rom();
    logic [LUT_DEPTH*DW-1:0] rom;
    rom = '0;
    for (int n = 0; n < LUT_DEPTH; n++) rom[n*DW +: DW] = sine_entry(n);
    return rom;
  endfunction

  function automatic logic [L*GW-1:0] build_gain_rom();
    logic [L*GW-1:0] rom;
    rom = '0;
    for (int k = 0; k < L; k++)
      rom[k*GW +: GW] = GW'((k * (2 ** GF) + (L - 1) / 2) / (L - 1));
    return rom;
  endfunction

  localparam logic [LUT_DEPTH*DW-1:0] SINE_ROM = build_sine_rom();
  localparam logic [L*GW-1:0]         GAIN_ROM = build_gain_rom();

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [PW-1:0]         phase;
  logic [PW-1:0]         phase_next;
  logic [CW-1:0]         sample_cnt;
  logic [SYM_BITS-1:0]   level;
  logic                  first;
  logic                  buf_full;
  logic [SYM_BITS-1:0]   buf_data;
  logic                  s1_valid;
  logic                  s1_first;
  logic signed [DW-1:0]  s1_sine;
  logic [GW-1:0]         s1_gain;
  logic signed [PRW-1:0] sine_ext;
  logic signed [PRW-1:0] gain_ext;
  logic signed [PRW-1:0] product;

  assign phase_next = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
  assign sym_ready  = !buf_full;
  assign busy       = (state == RUN) || s1_valid || dout_valid;
  assign sine_ext   = PRW'(s1_sine);
  assign gain_ext   = PRW'({1'b0, s1_gain});
  assign product    = sine_ext * gain_ext;

  // Sequencer (stage S0): the buffer can only be consumed while full and only accepts
  // while empty, so a refill always lands the cycle after a boundary consume.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      phase      <= '0;
      sample_cnt <= '0;
      level      <= '0;
      first      <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      underrun   <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      phase      <= '0;
      sample_cnt <= '0;
      level      <= '0;
      first      <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (sym_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= sym_data;
      end
      case (state)
        IDLE: begin
          if (buf_full) begin
            state      <= RUN;
            level      <= buf_data;
            phase      <= '0;
            sample_cnt <= '0;
            first      <= 1'b1;
            buf_full   <= 1'b0;
          end
        end
        RUN: begin
          if (sample_cnt == LAST_CNT) begin
            if (buf_full) begin
              level      <= buf_data;
              phase      <= phase_next;
              sample_cnt <= '0;
              first      <= 1'b1;
              buf_full   <= 1'b0;
            end else begin
              state      <= IDLE;
              phase      <= '0;
              sample_cnt <= '0;
              first      <= 1'b0;
              underrun   <= 1'b1;
            end
          end else begin
            phase      <= phase_next;
            sample_cnt <= sample_cnt + 1'b1;
            first      <= 1'b0;
          end
        end
      endcase
    end
  end

  // S1 registers the LUT read and gain; S2 scales with a flooring arithmetic shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_sine    <= '0;
      s1_gain    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sym_start  <= 1'b0;
    end else if (clr) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_sine    <= '0;
      s1_gain    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sym_start  <= 1'b0;
    end else begin
      s1_valid   <= (state == RUN);
      s1_first   <= (state == RUN) && first;
      s1_sine    <= SINE_ROM[phase*DW +: DW];
      s1_gain    <= GAIN_ROM[level*GW +: GW];
      dout_valid <= s1_valid;
      sym_start  <= s1_valid && s1_first;
      dout       <= s1_valid ? DW'(product >>> GF) : '0;
    end
  end

endmodule

// File: tb/tb_mask_mod.sv
// Scoreboard bench for mask_mod: a real-valued sine/gain model queues expected
// samples per accepted symbol; a negedge monitor pops and compares every live sample.
module tb_mask_mod;

  localparam int DW          = 12;
  localparam int SYM_BITS    = 2;
  localparam int LUT_DEPTH   = 25;
  localparam int CYC_PER_SYM = 1;
  localparam int GF          = 8;
  localparam int SPS         = LUT_DEPTH * CYC_PER_SYM;
  localparam int L           = 2 ** SYM_BITS;
  localparam real PI         = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic                 clr = 1'b0;
  logic                 sym_valid = 1'b0;
  logic [SYM_BITS-1:0]  sym_data = '0;
  logic                 sym_ready;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 sym_start;
  logic                 underrun;
  logic                 busy;

  mask_mod #(
    .DW(DW), .SYM_BITS(SYM_BITS), .LUT_DEPTH(LUT_DEPTH),
    .CYC_PER_SYM(CYC_PER_SYM), .GF(GF)
  ) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .dout(dout), .dout_valid(dout_valid), .sym_start(sym_start),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    bit start;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cap_q[$];
  int   lut_model[LUT_DEPTH];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cur_run = 0;
  int   last_run = 0;
  int   first_valid_cyc = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   underrun_cnt = 0;
  int   accept_cyc = 0;

  function automatic void check_output(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  function automatic int model_sample(int k, int n);
    real g;
    g = $floor(real'(k) * (2.0 ** GF) / real'(L - 1) + 0.5);
    return $rtoi($floor(real'(lut_model[n % LUT_DEPTH]) * g / (2.0 ** GF)));
  endfunction

  function automatic int cap_at(int i);
    return (i < cap_q.size()) ? cap_q[i] : -99999;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: compares every live sample against the scoreboard, tracks run shape
  always @(negedge clk) begin
    if (rstn) begin
      if (underrun) underrun_cnt++;
      if (dout_valid) begin
        if (cur_run == 0) first_valid_cyc = cyc;
        if (sym_start) begin
          if (cur_run > 0) check_output("start_spacing", cyc - last_start_cyc, SPS);
          last_start_cyc = cyc;
          start_cnt++;
        end
        cur_run++;
        cap_q.push_back(int'(dout));
        if (exp_q.size() == 0) begin
          fail_now("unexpected_sample");
        end else begin
          mon_e = exp_q.pop_front();
          check_output("sample", int'(dout), mon_e.d);
          check_output("sym_start", int'(sym_start), int'(mon_e.start));
        end
      end else begin
        if (cur_run > 0) last_run = cur_run;
        cur_run = 0;
        check_output("idle_dout_zero", int'(dout), 0);
        check_output("idle_sym_start", int'(sym_start), 0);
      end
    end
  end

  task automatic push_expected(input int k);
    for (int n = 0; n < SPS; n++) exp_q.push_back('{model_sample(k, n), n == 0});
  endtask

  task automatic apply_stimulus(input int k);
    int waited;
    waited    = 0;
    sym_valid = 1'b1;
    sym_data  = SYM_BITS'(k);
    while (!sym_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!sym_ready) begin
      fail_now("accept_timeout");
    end else begin
      accept_cyc = cyc + 1;
      push_expected(k);
      @(posedge clk); #1;
    end
  endtask

  task automatic release_inputs();
    sym_valid = 1'b0;
    sym_data  = '0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    repeat (3) @(posedge clk);
    #1;
    while ((busy || exp_q.size() != 0) && waited < 600) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("busy_low", int'(busy), 0);
    check_output("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_marks();
    cap_q.delete();
    start_cnt    = 0;
    underrun_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, gap, b_cyc, u0, nz;
    for (int n = 0; n < LUT_DEPTH; n++) begin
      real r;
      r = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * PI * n / LUT_DEPTH);
      lut_model[n] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end

    #2 rstn = 1'b0;
    #1;
    check_output("rst_dout", int'(dout), 0);
    check_output("rst_dout_valid", int'(dout_valid), 0);
    check_output("rst_sym_ready", int'(sym_ready), 1);
    check_output("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single symbol k=3");
    clear_marks();
    apply_stimulus(3);
    release_inputs();
    wait_idle();
    check_output("t1_latency", first_valid_cyc - accept_cyc, 3);
    check_output("t1_run_len", last_run, SPS);
    check_output("t1_starts", start_cnt, 1);
    check_output("t1_underrun", underrun_cnt, 1);
    check_output("t1_peak", cap_at(6), 2043);

    $display("[TB] symbols k=1 then k=2");
    clear_marks();
    apply_stimulus(1);
    apply_stimulus(2);
    release_inputs();
    wait_idle();
    check_output("t2_k1_s6", cap_at(6), 678);
    check_output("t2_k1_s19", cap_at(19), -679);
    check_output("t2_k2_s6", cap_at(SPS + 6), 1364);
    check_output("t2_k2_s19", cap_at(SPS + 19), -1365);
    check_output("t2_run_len", last_run, 2 * SPS);

    $display("[TB] back-to-back stream 0,3,1,2");
    clear_marks();
    apply_stimulus(0);
    apply_stimulus(3);
    apply_stimulus(1);
    apply_stimulus(2);
    release_inputs();
    wait_idle();
    check_output("t3_run_len", last_run, 4 * SPS);
    check_output("t3_starts", start_cnt, 4);
    check_output("t3_underrun", underrun_cnt, 1);
    nz = 0;
    for (int i = 0; i < SPS; i++) if (cap_at(i) != 0) nz++;
    check_output("t3_k0_zero", nz, 0);

    $display("[TB] backpressure");
    clear_marks();
    apply_stimulus(3);
    apply_stimulus(1);
    b_cyc = accept_cyc;
    check_output("t4_ready_low", int'(sym_ready), 0);
    apply_stimulus(2);
    check_output("t4_accept_edge", accept_cyc - b_cyc, SPS);
    release_inputs();
    wait_idle();
    check_output("t4_run_len", last_run, 3 * SPS);
    check_output("t4_underrun", underrun_cnt, 1);

    $display("[TB] clr mid-symbol");
    clear_marks();
    apply_stimulus(3);
    release_inputs();
    repeat (10) @(posedge clk);
    #1;
    u0        = underrun_cnt;
    clr       = 1'b1;
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    @(posedge clk); #1;
    clr = 1'b0;
    release_inputs();
    exp_q.delete();
    check_output("t5_dout_valid", int'(dout_valid), 0);
    check_output("t5_dout", int'(dout), 0);
    check_output("t5_busy", int'(busy), 0);
    check_output("t5_not_accepted", int'(sym_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check_output("t5_no_underrun", underrun_cnt, u0);
    clear_marks();
    apply_stimulus(3);
    release_inputs();
    wait_idle();
    check_output("t5_latency", first_valid_cyc - accept_cyc, 3);
    check_output("t5_restart_peak", cap_at(6), 2043);

    $display("[TB] reset mid-symbol with buffer full");
    clear_marks();
    apply_stimulus(3);
    apply_stimulus(2);
    release_inputs();
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_output("t6_dout", int'(dout), 0);
    check_output("t6_dout_valid", int'(dout_valid), 0);
    check_output("t6_sym_start", int'(sym_start), 0);
    check_output("t6_underrun", int'(underrun), 0);
    check_output("t6_busy", int'(busy), 0);
    check_output("t6_sym_ready", int'(sym_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    clear_marks();
    apply_stimulus(3);
    release_inputs();
    wait_idle();
    check_output("t6_latency", first_valid_cyc - accept_cyc, 3);
    check_output("t6_run_len", last_run, SPS);
    check_output("t6_peak", cap_at(6), 2043);

    $display("[TB] randomized symbols with gaps");
    clear_marks();
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, L - 1));
      apply_stimulus(k);
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        release_inputs();
        repeat (gap * 15) @(posedge clk);
        #1;
      end
    end
    release_inputs();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
